// File: rtl/tictactoe_game_logic_if.sv
// tictactoe_game_logic_if: player buttons in, board/cursor/turn/result out
interface tictactoe_game_logic_if;
  logic btn_next;
  logic btn_place;
  logic btn_restart;
  logic [1:0] block00, block01, block02;
  logic [1:0] block10, block11, block12;
  logic [1:0] block20, block21, block22;
  logic [3:0] selected;
  logic turn;
  logic [1:0] winner;
  logic game_over;
  modport master (
    output btn_next, btn_place, btn_restart,
    input block00, block01, block02, block10, block11, block12, block20, block21, block22,
    input selected, turn, winner, game_over
  );
  modport slave (
    input btn_next, btn_place, btn_restart,
    output block00, block01, block02, block10, block11, block12, block20, block21, block22,
    output selected, turn, winner, game_over
  );
endinterface

// File: rtl/tictactoe_game_logic.sv
// tictactoe_game_logic: board, cursor, turn, win/draw detection and per-turn timeout
module tictactoe_game_logic #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input logic CLOCK_50,
  input logic reset,
  tictactoe_game_logic_if.slave bus
);
  typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;
  state_t state_q, state_d;
  logic [8:0][1:0] board_q, board_d;
  logic [3:0] sel_q, sel_d, cnt_q, cnt_d;
  logic turn_q, turn_d, over_q, over_d;
  logic [1:0] winner_q, winner_d, line_w;
  logic [31:0] timer_q, timer_d;
  logic [2:0] btn_q, btn, edges;
  logic timeout, place_ok;

  function automatic logic [1:0] line(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    return (a == b && b == c) ? a : 2'b00;
  endfunction

  assign btn = {bus.btn_restart, bus.btn_place, bus.btn_next};
  assign edges = btn & ~btn_q;
  assign line_w = line(board_q[0], board_q[1], board_q[2]) | line(board_q[3], board_q[4], board_q[5]) |
                  line(board_q[6], board_q[7], board_q[8]) | line(board_q[0], board_q[3], board_q[6]) |
                  line(board_q[1], board_q[4], board_q[7]) | line(board_q[2], board_q[5], board_q[8]) |
                  line(board_q[0], board_q[4], board_q[8]) | line(board_q[2], board_q[4], board_q[6]);
  assign timeout = TIMEOUT_CYCLES != 0 && timer_q == 32'(TIMEOUT_CYCLES - 1);
  assign place_ok = edges[1] && board_q[sel_q] == 2'b00;

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    turn_d = turn_q;
    over_d = over_q;
    winner_d = winner_q;
    timer_d = timer_q;
    if (edges[2]) begin
      state_d = PLAY;
      board_d = '0;
      sel_d = '0;
      cnt_d = '0;
      turn_d = 1'b0;
      over_d = 1'b0;
      winner_d = 2'b00;
      timer_d = '0;
    end else if (state_q == PLAY) begin
      sel_d = edges[0] ? (sel_q == 4'd8 ? 4'd0 : sel_q + 4'd1) : sel_q;
      timer_d = (place_ok || timeout) ? '0 : timer_q + 32'd1;
      turn_d = (!place_ok && timeout) ? ~turn_q : turn_q;
      if (place_ok) begin
        board_d[sel_q] = {turn_q, ~turn_q};
        cnt_d = cnt_q + 4'd1;
        state_d = CHECK;
      end
    end else if (state_q == CHECK) begin
      over_d = line_w != 2'b00 || cnt_q == 4'd9;
      winner_d = line_w != 2'b00 ? line_w : cnt_q == 4'd9 ? 2'b11 : 2'b00;
      turn_d = over_d ? turn_q : ~turn_q;
      state_d = line_w != 2'b00 ? WIN : cnt_q == 4'd9 ? DRAW : PLAY;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= PLAY;
      board_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      turn_q <= 1'b0;
      over_q <= 1'b0;
      winner_q <= 2'b00;
      timer_q <= '0;
      btn_q <= '1;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      turn_q <= turn_d;
      over_q <= over_d;
      winner_q <= winner_d;
      timer_q <= timer_d;
      btn_q <= btn;
    end
  end

  assign bus.block00 = board_q[0];
  assign bus.block01 = board_q[1];
  assign bus.block02 = board_q[2];
  assign bus.block10 = board_q[3];
  assign bus.block11 = board_q[4];
  assign bus.block12 = board_q[5];
  assign bus.block20 = board_q[6];
  assign bus.block21 = board_q[7];
  assign bus.block22 = board_q[8];
  assign bus.selected = sel_q;
  assign bus.turn = turn_q;
  assign bus.winner = winner_q;
  assign bus.game_over = over_q;
endmodule

// File: tb/tb_tictactoe_game_logic.sv
// tb_tictactoe_game_logic: directed checks of reset, cursor, win, draw, restart and timeout
module tb_tictactoe_game_logic;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic nx = 1'b0, pl = 1'b0, rs = 1'b0;
  logic tnx = 1'b0, tpl = 1'b0, trs = 1'b0;
  int vec = 0;
  int errs = 0;
  int cur = 0;

  tictactoe_game_logic_if a ();
  tictactoe_game_logic_if t ();
  assign a.btn_next = nx;
  assign a.btn_place = pl;
  assign a.btn_restart = rs;
  assign t.btn_next = tnx;
  assign t.btn_place = tpl;
  assign t.btn_restart = trs;

  tictactoe_game_logic dut (.CLOCK_50(clk), .reset(reset), .bus(a));
  tictactoe_game_logic #(.TIMEOUT_CYCLES(10)) dut_t (.CLOCK_50(clk), .reset(reset), .bus(t));

  always #5 clk = ~clk;

  function automatic logic [17:0] brd();
    return {a.block22, a.block21, a.block20, a.block12, a.block11, a.block10, a.block02, a.block01, a.block00};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic n, input logic p, input logic r);
    nx = n;
    pl = p;
    rs = r;
    tick();
    nx = 1'b0;
    pl = 1'b0;
    rs = 1'b0;
    tick();
  endtask

  task automatic goto(input int idx);
    while (cur != idx) begin
      pulse(1'b1, 1'b0, 1'b0);
      cur = (cur + 1) % 9;
    end
  endtask

  task automatic move(input int idx);
    goto(idx);
    pulse(1'b0, 1'b1, 1'b0);
  endtask

  task automatic restart();
    pulse(1'b0, 1'b0, 1'b1);
    cur = 0;
  endtask

  initial begin
    nx = 1'b1;
    pl = 1'b1;
    rs = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tick();
    chk("reset_board", 32'(brd()), 32'h0);
    chk("reset_sel", 32'(a.selected), 32'd0);
    chk("reset_turn", 32'(a.turn), 32'd0);
    chk("reset_winner", 32'(a.winner), 32'd0);
    chk("reset_over", 32'(a.game_over), 32'd0);
    nx = 1'b0;
    pl = 1'b0;
    rs = 1'b0;
    tick();
    chk("held_no_fire_sel", 32'(a.selected), 32'd0);
    chk("held_no_fire_board", 32'(brd()), 32'h0);

    for (int i = 1; i <= 9; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      chk($sformatf("wrap_sel_%0d", i), 32'(a.selected), 32'(i % 9));
    end
    cur = 0;
    goto(4);
    nx = 1'b1;
    pl = 1'b1;
    tick();
    nx = 1'b0;
    pl = 1'b0;
    chk("next_place_block11", 32'(a.block11), 32'd1);
    chk("next_place_sel", 32'(a.selected), 32'd5);
    tick();
    chk("next_place_turn", 32'(a.turn), 32'd1);
    cur = 5;
    restart();
    chk("restart_board", 32'(brd()), 32'h0);
    chk("restart_turn", 32'(a.turn), 32'd0);

    move(0);
    move(3);
    move(1);
    move(4);
    move(2);
    chk("xwin_winner", 32'(a.winner), 32'd1);
    chk("xwin_over", 32'(a.game_over), 32'd1);
    chk("xwin_turn", 32'(a.turn), 32'd0);
    chk("xwin_board", 32'(brd()), 32'h295);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    chk("frozen_board", 32'(brd()), 32'h295);
    chk("frozen_sel", 32'(a.selected), 32'd2);

    restart();
    chk("rst_win_board", 32'(brd()), 32'h0);
    chk("rst_win_winner", 32'(a.winner), 32'd0);
    chk("rst_win_over", 32'(a.game_over), 32'd0);
    chk("rst_win_turn", 32'(a.turn), 32'd0);
    move(0);
    chk("after_win_first", 32'(a.block00), 32'd1);

    goto(1);
    pl = 1'b1;
    tick();
    pl = 1'b0;
    rs = 1'b1;
    tick();
    rs = 1'b0;
    cur = 0;
    chk("rst_check_board", 32'(brd()), 32'h0);
    chk("rst_check_winner", 32'(a.winner), 32'd0);
    chk("rst_check_turn", 32'(a.turn), 32'd0);
    chk("rst_check_sel", 32'(a.selected), 32'd0);
    tick();
    move(0);
    chk("after_check_first", 32'(a.block00), 32'd1);

    restart();
    pl = 1'b1;
    rs = 1'b1;
    tick();
    pl = 1'b0;
    rs = 1'b0;
    chk("rst_place_board", 32'(brd()), 32'h0);
    chk("rst_place_turn", 32'(a.turn), 32'd0);
    tick();
    move(0);
    chk("after_place_first", 32'(a.block00), 32'd1);
    chk("after_place_turn", 32'(a.turn), 32'd1);

    restart();
    move(0);
    move(1);
    move(2);
    move(4);
    move(0);
    chk("occupied_board", 32'(brd()), 32'h219);
    chk("occupied_turn", 32'(a.turn), 32'd0);
    move(3);
    move(5);
    move(7);
    move(6);
    chk("pre_draw_over", 32'(a.game_over), 32'd0);
    move(8);
    chk("draw_winner", 32'(a.winner), 32'd3);
    chk("draw_over", 32'(a.game_over), 32'd1);
    chk("draw_board", 32'(brd()), 32'h16A59);

    trs = 1'b1;
    tick();
    trs = 1'b0;
    repeat (9) tick();
    chk("to_before_first", 32'(t.turn), 32'd0);
    tick();
    chk("to_first_toggle", 32'(t.turn), 32'd1);
    repeat (9) tick();
    chk("to_before_second", 32'(t.turn), 32'd1);
    tick();
    chk("to_second_toggle", 32'(t.turn), 32'd0);
    repeat (9) tick();
    tpl = 1'b1;
    tick();
    tpl = 1'b0;
    chk("to_place_cell", 32'(t.block00), 32'd1);
    chk("to_place_turn", 32'(t.turn), 32'd0);
    tick();
    chk("to_place_check_turn", 32'(t.turn), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
